button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 119 +++++++++++
 tb/tb_button_conditioner.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - per-channel synchroniser, debouncer, edge detector and auto-repeat generator
module button_conditioner #(
  parameter int               WIDTH         = 4,
  parameter int               SYNC_STAGES   = 2,
  parameter int               DEBOUNCE_BITS = 16,
  parameter logic [WIDTH-1:0] INVERT        = {WIDTH{1'b0}},
  parameter int               REPEAT_DELAY  = 12500000,
  parameter int               REPEAT_PERIOD = 2500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] rpt
);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;

  localparam logic [DEBOUNCE_BITS-1:0] CNT_MAX     = '1;
  localparam logic [23:0]              DELAY_LAST  = 24'(REPEAT_DELAY - 1);
  localparam logic [23:0]              PERIOD_LAST = 24'(REPEAT_PERIOD - 1);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0]   sync;
    logic [DEBOUNCE_BITS-1:0] cnt;
    logic                     lvl;
    logic                     q_r;
    logic                     rise_r;
    logic                     fall_r;
    logic                     rpt_r;
    rpt_state_t               state;
    logic [23:0]              rc;
    logic                     s;
    logic                     going_up;
    logic                     going_down;

    // lvl is the debounced level; q trails it by one flop so q, rise, fall and rpt all update together.
    assign s          = sync[SYNC_STAGES-1];
    assign going_up   = lvl & ~q_r;
    assign going_down = ~lvl & q_r;

    always_ff @(posedge clk) begin
      if (reset) begin
        sync   <= '0;
        cnt    <= '0;
        lvl    <= 1'b0;
        q_r    <= 1'b0;
        rise_r <= 1'b0;
        fall_r <= 1'b0;
        rpt_r  <= 1'b0;
        state  <= IDLE;
        rc     <= '0;
      end else begin
        sync <= {sync[SYNC_STAGES-2:0], d[i] ^ INVERT[i]};

        // Any sample matching the current level restarts the window.
        if (s == lvl) begin
          cnt <= '0;
        end else if (cnt == CNT_MAX) begin
          lvl <= s;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end

        q_r    <= lvl;
        rise_r <= going_up;
        fall_r <= going_down;
        rpt_r  <= 1'b0;

        case (state)
          IDLE: begin
            if (going_up) begin
              rpt_r <= 1'b1;
              rc    <= '0;
              if (REPEAT_DELAY != 0) state <= DELAY;
            end
          end
          DELAY: begin
            if (going_down) begin
              state <= IDLE;
              rc    <= '0;
            end else if (rc == DELAY_LAST) begin
              rpt_r <= 1'b1;
              rc    <= '0;
              state <= REPEAT;
            end else begin
              rc <= rc + 24'd1;
            end
          end
          REPEAT: begin
            // Release wins over a repeat expiring on the same edge.
            if (going_down) begin
              state <= IDLE;
              rc    <= '0;
            end else if (rc == PERIOD_LAST) begin
              rpt_r <= 1'b1;
              rc    <= '0;
            end else begin
              rc <= rc + 24'd1;
            end
          end
          default: begin
            state <= IDLE;
            rc    <= '0;
          end
        endcase
      end
    end

    assign q[i]    = q_r;
    assign rise[i] = rise_r;
    assign fall[i] = fall_r;
    assign rpt[i]  = rpt_r;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] d;
  logic [3:0] q;
  logic [3:0] rise;
  logic [3:0] fall;
  logic [3:0] rpt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int         cyc;
    logic [3:0] r;
    logic [3:0] f;
    logic [3:0] p;
  } ev_t;

  ev_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  button_conditioner #(
    .WIDTH(4),
    .SYNC_STAGES(2),
    .DEBOUNCE_BITS(3),
    .INVERT(4'b0001),
    .REPEAT_DELAY(20),
    .REPEAT_PERIOD(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .d(d),
    .q(q),
    .rise(rise),
    .fall(fall),
    .rpt(rpt)
  );

  // Pulses are sampled at the falling edge; cyc then equals the number of rising edges so far.
  always @(negedge clk) begin
    if (mon_en) begin
      ev_t        e;
      logic [3:0] er;
      logic [3:0] ef;
      logic [3:0] ep;
      bit         have;
      er = '0; ef = '0; ep = '0; have = 1'b0;
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        e = sbq.pop_front();
        checks++; errors++;
        $display("FAIL missed_event: expected at cyc %0d rise=%b fall=%b rpt=%b, not observed", e.cyc, e.r, e.f, e.p);
      end
      if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        e = sbq.pop_front();
        er = e.r; ef = e.f; ep = e.p; have = 1'b1;
      end
      if (have || (rise | fall | rpt) != 4'b0) begin
        checks++;
        if ({rise, fall, rpt} !== {er, ef, ep}) begin
          errors++;
          $display("FAIL pulses cyc=%0d: rise=%b fall=%b rpt=%b expected rise=%b fall=%b rpt=%b",
                   cyc, rise, fall, rpt, er, ef, ep);
        end
      end
    end
  end

  task automatic push(input int c, input logic [3:0] r, input logic [3:0] f, input logic [3:0] p);
    ev_t e;
    e.cyc = c; e.r = r; e.f = f; e.p = p;
    sbq.push_back(e);
  endtask

  // Changes d just after a rising edge; the next rising edge (edge 0) samples it and
  // the result of edge k is seen at the falling edge where cyc == base + 1 + k.
  task automatic drive(input logic [3:0] v, output int base);
    @(posedge clk); #1;
    d    = v;
    base = cyc;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    d     = 4'b0001;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({q, rise, fall, rpt} !== 16'h0) begin
      errors++; $display("FAIL reset_state: q=%b rise=%b fall=%b rpt=%b required all 0", q, rise, fall, rpt);
    end
    @(posedge clk); #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (q !== 4'b0000) begin
      errors++; $display("FAIL idle_inverted_high: q=%b required 0000", q);
    end
  endtask

  task automatic test_clean_press();
    int b;
    int r;
    drive(4'b0011, b);
    push(b + 11, 4'b0010, 4'b0000, 4'b0010);
    wait_to(b + 10);
    checks++; if (q[1] !== 1'b0) begin errors++; $display("FAIL press_edge9: q[1]=%b required 0", q[1]); end
    wait_to(b + 11);
    checks++; if (q[1] !== 1'b1) begin errors++; $display("FAIL press_edge10: q[1]=%b required 1", q[1]); end
    drive(4'b0001, r);
    push(r + 11, 4'b0000, 4'b0010, 4'b0000);
    wait_to(r + 10);
    checks++; if (q[1] !== 1'b1) begin errors++; $display("FAIL release_edge9: q[1]=%b required 1", q[1]); end
    wait_to(r + 11);
    checks++; if (q[1] !== 1'b0) begin errors++; $display("FAIL release_edge10: q[1]=%b required 0", q[1]); end
    wait_to(r + 40);
  endtask

  task automatic test_glitch();
    int b;
    int b2;
    drive(4'b0101, b);
    repeat (7) @(posedge clk);
    #1 d = 4'b0001;
    wait_to(b + 25);
    checks++; if (q[2] !== 1'b0) begin errors++; $display("FAIL glitch7: q[2]=%b required 0", q[2]); end
    drive(4'b0101, b2);
    push(b2 + 11, 4'b0100, 4'b0000, 4'b0100);
    repeat (8) @(posedge clk);
    #1 d = 4'b0001;
    push(b2 + 19, 4'b0000, 4'b0100, 4'b0000);
    wait_to(b2 + 11);
    checks++; if (q[2] !== 1'b1) begin errors++; $display("FAIL pulse8: q[2]=%b required 1", q[2]); end
    wait_to(b2 + 30);
  endtask

  task automatic test_polarity();
    int b;
    int r;
    drive(4'b0000, b);
    push(b + 11, 4'b0001, 4'b0000, 4'b0001);
    wait_to(b + 10);
    checks++; if (q[0] !== 1'b0) begin errors++; $display("FAIL inv_edge9: q[0]=%b required 0", q[0]); end
    wait_to(b + 11);
    checks++; if (q[0] !== 1'b1) begin errors++; $display("FAIL inv_edge10: q[0]=%b required 1", q[0]); end
    drive(4'b0001, r);
    push(r + 11, 4'b0000, 4'b0001, 4'b0000);
    wait_to(r + 30);
    checks++; if (q[0] !== 1'b0) begin errors++; $display("FAIL inv_release: q[0]=%b required 0", q[0]); end
  endtask

  task automatic test_auto_repeat();
    int b;
    int e;
    int r;
    drive(4'b1001, b);
    e = b + 11;
    push(e, 4'b1000, 4'b0000, 4'b1000);
    for (int k = 0; k < 8; k++) push(e + 20 + 5 * k, 4'b0000, 4'b0000, 4'b1000);
    wait_to(b + 59);
    // Release lands so the fall coincides with the repeat that would fire at e+60.
    drive(4'b0001, r);
    push(r + 11, 4'b0000, 4'b1000, 4'b0000);
    checks++; if (r + 11 !== e + 60) begin errors++; $display("FAIL repeat_align: fall cyc %0d required %0d", r + 11, e + 60); end
    wait_to(r + 10);
    checks++; if (q[3] !== 1'b1) begin errors++; $display("FAIL repeat_held: q[3]=%b required 1", q[3]); end
    wait_to(r + 45);
  endtask

  task automatic test_reset_in_delay();
    int b;
    int e;
    int r;
    drive(4'b0011, b);
    e = b + 11;
    push(e, 4'b0010, 4'b0000, 4'b0010);
    wait_to(e + 4);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({q, rise, fall, rpt} !== 16'h0) begin
      errors++; $display("FAIL reset_mid: q=%b rise=%b fall=%b rpt=%b required all 0", q, rise, fall, rpt);
    end
    push(e + 16, 4'b0010, 4'b0000, 4'b0010);
    wait_to(e + 15);
    checks++; if (q[1] !== 1'b0) begin errors++; $display("FAIL repress_edge9: q[1]=%b required 0", q[1]); end
    wait_to(e + 16);
    checks++; if (q[1] !== 1'b1) begin errors++; $display("FAIL repress_edge10: q[1]=%b required 1", q[1]); end
    drive(4'b0001, r);
    push(r + 11, 4'b0000, 4'b0010, 4'b0000);
    wait_to(r + 40);
  endtask

  task automatic test_simultaneous();
    int b;
    int r;
    int r2;
    drive(4'b0011, b);
    push(b + 11, 4'b0010, 4'b0000, 4'b0010);
    wait_to(b + 11);
    drive(4'b0101, r);
    push(r + 11, 4'b0100, 4'b0010, 4'b0100);
    wait_to(r + 11);
    checks++; if (q !== 4'b0100) begin errors++; $display("FAIL swap_q: q=%b required 0100", q); end
    drive(4'b0001, r2);
    push(r2 + 11, 4'b0000, 4'b0100, 4'b0000);
    wait_to(r2 + 30);
  endtask

  initial begin
    d     = 4'b0001;
    reset = 1'b1;
    test_reset();
    test_clean_press();
    test_glitch();
    test_polarity();
    test_auto_repeat();
    test_reset_in_delay();
    test_simultaneous();
    repeat (5) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d events left, required 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
